// File: rtl/datapath_pkg.sv
// Shared datapath types: register/word widths, scalar FU indices, writeback request and result records.
package datapath_pkg;

    typedef logic [4:0]  regbits_t;
    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FU_S_ALU    = 2'd0,
        FU_S_LD_ST  = 2'd1,
        FU_S_BRANCH = 2'd2
    } fu_scalar_t;

    localparam int unsigned WB_NREQ = 3;

    typedef struct packed {
        logic     wen;
        regbits_t rd;
        word_t    data;
        logic     is_load;
    } wb_req_t;

    typedef struct packed {
        logic     s_rw_en;
        regbits_t s_rw;
        word_t    s_wdata;
        logic     load_done;
        logic     alu_done;
    } wb_t;

endpackage

// File: rtl/wb_arbiter_pkg.sv
// Writeback-arbiter local constants layered on datapath_pkg.
package wb_arbiter_pkg;
    import datapath_pkg::*;

    localparam int unsigned WB_SRC_W = 2;
    localparam int unsigned LDST_IDX = 1;

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback request/result bundle between scalar FUs (master) and wb_arbiter (slave).
interface wb_arbiter_if #(
    parameter int unsigned NREQ = 3
);
    import datapath_pkg::*;

    logic [NREQ-1:0]          req_valid;
    wb_req_t [NREQ-1:0]       req;
    logic [NREQ-1:0]          req_ready;
    logic                     wb_valid;
    logic [1:0]               wb_src;
    wb_t                      wb;

    modport master (
        output req_valid, req,
        input  req_ready, wb_valid, wb_src, wb
    );

    modport slave (
        input  req_valid, req,
        output req_ready, wb_valid, wb_src, wb
    );

endinterface

// File: rtl/wb_arbiter_rr.sv
// Round-robin arbiter (module rr_arbiter): one-hot grant from req, pointer advances past the winner when en.
module rr_arbiter #(
    parameter int unsigned NREQ = 3
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    output logic [NREQ-1:0] grant
);
    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_next;
    logic          found;
    int unsigned   target;

    always_comb begin
        grant  = '0;
        found  = 1'b0;
        target = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            target = 32'(ptr) + k;
            if (target >= NREQ) target = target - NREQ;
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (!found && req[i] && (i == target)) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

    always_comb begin
        ptr_next = ptr;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) ptr_next = (i + 1 == NREQ) ? '0 : PW'(i + 1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST)                ptr <= '0;
        else if (en && |grant)    ptr <= ptr_next;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Scalar writeback arbiter: one hold buffer per FU, one registered writeback per cycle.
// Optional macro WB_ARB_LD_PRIO_EN gives FU_S_LD_ST absolute priority over the round-robin.
module wb_arbiter
    import datapath_pkg::*;
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 3
) (
    input  logic          CLK,
    input  logic          nRST,
    wb_arbiter_if.slave   bus
);
    logic [NREQ-1:0] hold_valid;
    wb_req_t         hold [NREQ];
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] rr_req;
    logic [NREQ-1:0] rr_grant;
    logic            rr_en;
    wb_req_t         sel;
    logic [1:0]      src_next;
    wb_t             wb_next;

`ifdef WB_ARB_LD_PRIO_EN
    // Load/store is pulled out of the rotation; the pointer only moves on ALU/BRANCH grants.
    always_comb begin
        rr_req           = hold_valid;
        rr_req[LDST_IDX] = 1'b0;
        rr_en            = !hold_valid[LDST_IDX];
        grant            = rr_grant;
        if (hold_valid[LDST_IDX]) begin
            grant           = '0;
            grant[LDST_IDX] = 1'b1;
        end
    end
`else
    always_comb begin
        rr_req = hold_valid;
        rr_en  = 1'b1;
        grant  = rr_grant;
    end
`endif

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .CLK   (CLK),
        .nRST  (nRST),
        .req   (rr_req),
        .en    (rr_en),
        .grant (rr_grant)
    );

    assign bus.req_ready = ~hold_valid | grant;

    always_comb begin
        sel      = '0;
        src_next = '0;
        wb_next  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel      = hold[i];
                src_next = 2'(i);
            end
        end
        if (|grant) begin
            wb_next.s_rw_en   = sel.wen & (sel.rd != '0);
            wb_next.s_rw      = sel.rd;
            wb_next.s_wdata   = sel.data;
            wb_next.alu_done  = (src_next == FU_S_ALU);
            wb_next.load_done = (src_next == FU_S_LD_ST) & sel.is_load;
        end
    end

    // A refill in the grant cycle overrides the clear, so the drained slot never goes empty.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            hold_valid   <= '0;
            bus.wb_valid <= 1'b0;
            bus.wb_src   <= '0;
            bus.wb       <= '0;
            for (int unsigned i = 0; i < NREQ; i++) hold[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    hold_valid[i] <= 1'b1;
                    hold[i]       <= bus.req[i];
                end else if (grant[i]) begin
                    hold_valid[i] <= 1'b0;
                end
            end
            bus.wb_valid <= |grant;
            bus.wb_src   <= src_next;
            bus.wb       <= wb_next;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (expectations follow WB_ARB_LD_PRIO_EN when defined).
module tb_wb_arbiter;
    import datapath_pkg::*;

    logic clk = 1'b0;
    logic nrst;
    int   checks = 0;
    int   errors = 0;

    wb_arbiter_if #(.NREQ(3)) bus ();

    wb_arbiter #(.NREQ(3)) dut (
        .CLK  (clk),
        .nRST (nrst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic wb_req_t mk(logic wen, logic [4:0] rd, logic [31:0] data, logic is_load);
        wb_req_t r;
        r.wen     = wen;
        r.rd      = rd;
        r.data    = data;
        r.is_load = is_load;
        return r;
    endfunction

    task automatic do_reset();
        nrst = 1'b0;
        bus.req_valid = '0;
        tick();
        tick();
        nrst = 1'b1;
    endtask

    logic [2:0]  rdy_tab [3];
    logic [1:0]  src_tab [3];
    logic [1:0]  exp_src;

    initial begin
        bus.req_valid = '0;
        for (int i = 0; i < 3; i++) bus.req[i] = '0;
        do_reset();

        check("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
        check("rst_wb_src",   64'(bus.wb_src),   64'd0);
        check("rst_wb",       64'(bus.wb),       64'd0);
        check("rst_ready",    64'(bus.req_ready), 64'b111);

        // single ALU request
        bus.req[0] = mk(1'b1, 5'd5, 32'h1234, 1'b0);
        bus.req_valid = 3'b001;
        tick();
        bus.req_valid = '0;
        check("single_early", 64'(bus.wb_valid), 64'd0);
        tick();
        check("single_valid",  64'(bus.wb_valid),        64'd1);
        check("single_src",    64'(bus.wb_src),          64'd0);
        check("single_en",     64'(bus.wb.s_rw_en),      64'd1);
        check("single_rd",     64'(bus.wb.s_rw),         64'd5);
        check("single_data",   64'(bus.wb.s_wdata),      64'h1234);
        check("single_alu",    64'(bus.wb.alu_done),     64'd1);
        check("single_ld",     64'(bus.wb.load_done),    64'd0);
        tick();
        check("single_idle_v", 64'(bus.wb_valid), 64'd0);
        check("single_idle_w", 64'(bus.wb),       64'd0);

        // three simultaneous requests from a fresh reset
        do_reset();
`ifdef WB_ARB_LD_PRIO_EN
        rdy_tab = '{3'b010, 3'b011, 3'b111};
        src_tab = '{2'd1, 2'd0, 2'd2};
`else
        rdy_tab = '{3'b001, 3'b011, 3'b111};
        src_tab = '{2'd0, 2'd1, 2'd2};
`endif
        bus.req[0] = mk(1'b1, 5'd1, 32'hA0, 1'b0);
        bus.req[1] = mk(1'b1, 5'd2, 32'hB0, 1'b1);
        bus.req[2] = mk(1'b1, 5'd3, 32'hC0, 1'b0);
        bus.req_valid = 3'b111;
        tick();
        bus.req_valid = '0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("tri_ready%0d", k), 64'(bus.req_ready), 64'(rdy_tab[k]));
            tick();
            check($sformatf("tri_valid%0d", k), 64'(bus.wb_valid), 64'd1);
            check($sformatf("tri_src%0d", k),   64'(bus.wb_src),   64'(src_tab[k]));
            check($sformatf("tri_data%0d", k),  64'(bus.wb.s_wdata),
                  64'(32'hA0 + 32'h10 * 32'(src_tab[k])));
            check($sformatf("tri_ld%0d", k),    64'(bus.wb.load_done), 64'(src_tab[k] == 2'd1));
            check($sformatf("tri_alu%0d", k),   64'(bus.wb.alu_done),  64'(src_tab[k] == 2'd0));
        end
        tick();
        check("tri_done", 64'(bus.wb_valid), 64'd0);

        // write to x0 from ALU
        bus.req[0] = mk(1'b1, 5'd0, 32'hDEAD, 1'b0);
        bus.req_valid = 3'b001;
        tick();
        bus.req_valid = '0;
        tick();
        check("x0_valid", 64'(bus.wb_valid),     64'd1);
        check("x0_en",    64'(bus.wb.s_rw_en),   64'd0);
        check("x0_alu",   64'(bus.wb.alu_done),  64'd1);

        // store from LD/ST
        bus.req[1] = mk(1'b0, 5'd7, 32'h55, 1'b0);
        bus.req_valid = 3'b010;
        tick();
        bus.req_valid = '0;
        tick();
        check("st_valid", 64'(bus.wb_valid),      64'd1);
        check("st_src",   64'(bus.wb_src),        64'd1);
        check("st_en",    64'(bus.wb.s_rw_en),    64'd0);
        check("st_ld",    64'(bus.wb.load_done),  64'd0);
        check("st_alu",   64'(bus.wb.alu_done),   64'd0);
        tick();

        // back-to-back ALU stream
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                bus.req[0] = mk(1'b1, 5'd9, 32'h100 + 32'(i), 1'b0);
                bus.req_valid = 3'b001;
                check($sformatf("b2b_ready%0d", i), 64'(bus.req_ready[0]), 64'd1);
            end else begin
                bus.req_valid = '0;
            end
            tick();
            if (i >= 1 && i <= 8) begin
                check($sformatf("b2b_valid%0d", i), 64'(bus.wb_valid),   64'd1);
                check($sformatf("b2b_data%0d", i),  64'(bus.wb.s_wdata), 64'(32'h100 + 32'(i - 1)));
            end
        end
        check("b2b_end", 64'(bus.wb_valid), 64'd0);

        // reset mid-stream with full buffers
        bus.req[0] = mk(1'b1, 5'd1, 32'h11, 1'b0);
        bus.req[1] = mk(1'b1, 5'd2, 32'h22, 1'b1);
        bus.req[2] = mk(1'b1, 5'd3, 32'h33, 1'b0);
        bus.req_valid = 3'b111;
        tick();
        bus.req_valid = '0;
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        check("mrst_ready", 64'(bus.req_ready), 64'b111);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("mrst_valid%0d", k), 64'(bus.wb_valid), 64'd0);
            check($sformatf("mrst_wb%0d", k),    64'(bus.wb),       64'd0);
            tick();
        end

        // ALU and LD/ST continuously valid
        do_reset();
        bus.req[0] = mk(1'b1, 5'd4, 32'h44, 1'b0);
        bus.req[1] = mk(1'b1, 5'd6, 32'h66, 1'b1);
        bus.req_valid = 3'b011;
        tick();
        for (int k = 0; k < 6; k++) begin
            tick();
`ifdef WB_ARB_LD_PRIO_EN
            exp_src = 2'd1;
`else
            exp_src = (k % 2 == 0) ? 2'd0 : 2'd1;
`endif
            check($sformatf("prio_valid%0d", k), 64'(bus.wb_valid), 64'd1);
            check($sformatf("prio_src%0d", k),   64'(bus.wb_src),   64'(exp_src));
        end
        bus.req_valid = '0;
        tick();
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
